div_controller: RTL and testbench

DIV_CONTROLLER -- requirements
Module: div_controller

---
 rtl/div_ctrl_pkg.sv | 22 ++
 rtl/div_sign_fix.sv | 17 +
 rtl/div_controller.sv | 164 ++++++++++++++++
 tb/tb_div_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: definitions shared by the divide controller and its helper.
//   - div_state_e     : controller FSM states
//   - DIV_DATA_WIDTH  : default operand/result width
//   - DIV_TIMEOUT     : default number of WAIT cycles before the operation aborts
//   - DIV_ALL_ONES    : quotient returned for divide by zero (default width)
//   - DIV_MIN_INT     : most negative value, dividend of the signed-overflow case
package div_ctrl_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_TIMEOUT    = 64;

  localparam logic [DIV_DATA_WIDTH-1:0] DIV_ALL_ONES = '1;
  localparam logic [DIV_DATA_WIDTH-1:0] DIV_MIN_INT  = {1'b1, {(DIV_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FIXUP  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational conditional two's-complement negate.
// With neg tied to the operand sign bit it produces a magnitude; with neg tied
// to a latched sign flag it restores the sign of a divider result.
//   a    in  WIDTH  value
//   neg  in  1      1 = negate a (mod 2^WIDTH)
//   y    out WIDTH  result
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/div_controller.sv
// div_controller: sequencing for DIV/DIVU between the core and an unsigned
// iterative divider. Strips operand signs, launches the divider, waits with a
// timeout, restores result signs and writes the architectural HI/LO pair.
// Divide by zero and the signed MIN_INT / -1 case finish in one cycle
// without touching the divider.
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid, req_signed       DIV/DIVU issue, 1 = signed
//   rs_val, rt_val              dividend, divisor
//   req_ready                   high only in IDLE
//   flush                       abort the operation in flight
//   hilo_rd                     core reading HI/LO (MFHI/MFLO)
//   stall                       pipeline interlock for hilo_rd
//   div_start                   one-cycle divider start pulse
//   div_op1, div_op2            unsigned magnitudes to the divider
//   div_quotient, div_remainder divider results, valid with div_done
//   div_done                    divider completion
//   hi, lo                      remainder, quotient
//   err_div0, err_timeout       one-cycle error pulses
module div_controller
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int TIMEOUT    = DIV_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic                  req_ready,
  input  logic                  flush,
  input  logic                  hilo_rd,
  output logic                  stall,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_op1,
  output logic [DATA_WIDTH-1:0] div_op2,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  input  logic                  div_done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  err_div0,
  output logic                  err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Width-generic forms of the package constants.
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic                  neg_q, neg_r;
  logic [DATA_WIDTH-1:0] q_cap, r_cap;
  logic [DATA_WIDTH-1:0] rs_abs, rt_abs, lo_fix, hi_fix;
  logic                  rs_neg, rt_neg;
  logic                  accept, is_div0, is_ovf, timeout_hit;

  assign rs_neg      = req_signed & rs_val[DATA_WIDTH-1];
  assign rt_neg      = req_signed & rt_val[DATA_WIDTH-1];
  assign accept      = (state == IDLE) && req_valid;
  assign is_div0     = (rt_val == '0);
  assign is_ovf      = req_signed && (rs_val == MIN_INT) && (rt_val == ALL_ONES);
  // Hit during the TIMEOUT-th WAIT cycle, counting from 0 on WAIT entry.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  div_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_rs (.a(rs_val), .neg(rs_neg), .y(rs_abs));
  div_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_rt (.a(rt_val), .neg(rt_neg), .y(rt_abs));
  div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_q  (.a(q_cap),  .neg(neg_q),  .y(lo_fix));
  div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_r  (.a(r_cap),  .neg(neg_r),  .y(hi_fix));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept && !is_div0 && !is_ovf) state_nxt = LAUNCH;
      LAUNCH: state_nxt = flush ? IDLE : WAIT;
      WAIT: begin
        // Flush takes priority over both completion and timeout.
        if (flush)            state_nxt = IDLE;
        else if (div_done)    state_nxt = FIXUP;
        else if (timeout_hit) state_nxt = IDLE;
      end
      FIXUP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    div_start = (state == LAUNCH);
    stall     = hilo_rd && (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_op1     <= '0;
      div_op2     <= '0;
      q_cap       <= '0;
      r_cap       <= '0;
      hi          <= '0;
      lo          <= '0;
      err_div0    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_div0    <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            neg_q   <= req_signed & (rs_val[DATA_WIDTH-1] ^ rt_val[DATA_WIDTH-1]);
            neg_r   <= rs_neg;
            div_op1 <= rs_abs;
            div_op2 <= rt_abs;
            if (is_div0) begin
              hi       <= rs_val;
              lo       <= ALL_ONES;
              err_div0 <= 1'b1;
            end else if (is_ovf) begin
              hi <= '0;
              lo <= MIN_INT;
            end
          end
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          if (!flush) begin
            if (div_done) begin
              q_cap <= div_quotient;
              r_cap <= div_remainder;
            end else if (timeout_hit) begin
              err_timeout <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIXUP: begin
          if (!flush) begin
            lo <= lo_fix;
            hi <= hi_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: self-checking bench for div_controller. A behavioural
// divider answers div_start after a programmable latency (or never); expected
// HI/LO pairs are pushed to a scoreboard at issue and popped on completion.
module tb_div_controller;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_signed, flush, hilo_rd;
  logic [31:0] rs_val, rt_val;
  logic        req_ready, stall, div_start, err_div0, err_timeout;
  logic [31:0] div_op1, div_op2, hi, lo;
  logic [31:0] div_quotient  = '0;
  logic [31:0] div_remainder = '0;
  logic        div_done      = 1'b0;

  div_controller #(.DATA_WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_signed(req_signed),
    .rs_val(rs_val), .rt_val(rt_val), .req_ready(req_ready),
    .flush(flush), .hilo_rd(hilo_rd), .stall(stall),
    .div_start(div_start), .div_op1(div_op1), .div_op2(div_op2),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .hi(hi), .lo(lo),
    .err_div0(err_div0), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          start_cnt = 0, d0_cnt = 0, to_cnt = 0;
  int          model_lat   = 1;
  bit          model_never = 1'b0;
  bit          m_busy = 1'b0;
  int          m_cd   = 0;
  logic [31:0] m_q, m_r;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  // Pulse counters sample pre-edge values.
  always @(posedge clk) begin
    if (div_start)   start_cnt++;
    if (err_div0)    d0_cnt++;
    if (err_timeout) to_cnt++;
  end

  // Divider model, driven on the falling edge.
  always @(negedge clk) begin
    div_done = 1'b0;
    if (div_start) begin
      m_busy = 1'b1;
      m_cd   = model_lat;
      m_q    = (div_op2 != 0) ? div_op1 / div_op2 : ONES;
      m_r    = (div_op2 != 0) ? div_op1 % div_op2 : div_op1;
    end else if (m_busy && !model_never) begin
      if (m_cd <= 1) begin
        div_done      = 1'b1;
        div_quotient  = m_q;
        div_remainder = m_r;
        m_busy        = 1'b0;
      end else begin
        m_cd--;
      end
    end
  end

  function automatic res_t ref_model(input logic [31:0] rs, input logic [31:0] rt, input bit sgn);
    res_t r;
    if (rt == 0) begin
      r.hi = rs;
      r.lo = ONES;
    end else if (sgn && rs == MIN && rt == ONES) begin
      r.hi = '0;
      r.lo = MIN;
    end else if (sgn) begin
      r.lo = $signed(rs) / $signed(rt);
      r.hi = $signed(rs) % $signed(rt);
    end else begin
      r.lo = rs / rt;
      r.hi = rs % rt;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] rs, input logic [31:0] rt, input bit sgn);
    req_valid  = 1'b1;
    req_signed = sgn;
    rs_val     = rs;
    rt_val     = rt;
  endtask

  task automatic do_op(input logic [31:0] rs, input logic [31:0] rt, input bit sgn, input int lat);
    res_t e;
    int   s0, n;
    bit   normal;
    normal    = (rt != 0) && !(sgn && rs == MIN && rt == ONES);
    model_lat = lat;
    s0        = start_cnt;
    sb.push_back(ref_model(rs, rt, sgn));
    issue(rs, rt, sgn);
    step();
    req_valid = 1'b0;
    if (normal) begin
      check("div_op1", div_op1, (sgn && rs[31]) ? -rs : rs);
      check("div_op2", div_op2, (sgn && rt[31]) ? -rt : rt);
    end
    n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    check("op_complete", req_ready, 1);
    e = sb.pop_front();
    check("hi", hi, e.hi);
    check("lo", lo, e.lo);
    check("start_pulses", start_cnt - s0, normal ? 1 : 0);
    exp_hi = e.hi;
    exp_lo = e.lo;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, d0, t0, n;
    bit bad;
    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; flush = 1'b0; hilo_rd = 1'b1;
    rs_val = '0; rt_val = '0;
    step(); step();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_op1", div_op1, 0);
    check("rst_div_op2", div_op2, 0);
    check("rst_errs", {err_div0, err_timeout}, 0);
    rst = 1'b0; hilo_rd = 1'b0;
    step();

    // DIVU 121/11 with explicit latency from div_done to HI/LO
    model_lat = 3; s0 = start_cnt;
    issue(121, 11, 1'b0);
    step();
    req_valid = 1'b0;
    check("launch_start", div_start, 1);
    n = 0;
    while (!div_done && n < 100) begin step(); n++; end
    check("done_seen", div_done, 1);
    step();
    check("fixup_busy", req_ready, 0);
    check("fixup_lo_old", lo, 0);
    step();
    check("divu_lo", lo, 11);
    check("divu_hi", hi, 0);
    check("divu_idle", req_ready, 1);
    check("divu_starts", start_cnt - s0, 1);
    exp_hi = 0; exp_lo = 11;

    // DIV -7/2 -> op1=7, op2=2, LO=-3, HI=-1
    do_op(32'hFFFF_FFF9, 2, 1'b1, 2);
    check("div_m7_lo", lo, 32'hFFFF_FFFD);
    check("div_m7_hi", hi, 32'hFFFF_FFFF);

    // DIV 7/0
    d0 = d0_cnt; s0 = start_cnt;
    issue(7, 0, 1'b1);
    step();
    req_valid = 1'b0;
    check("div0_hi", hi, 7);
    check("div0_lo", lo, ONES);
    check("div0_err", err_div0, 1);
    check("div0_ready", req_ready, 1);
    step();
    check("div0_err_clear", err_div0, 0);
    check("div0_pulses", d0_cnt - d0, 1);
    check("div0_starts", start_cnt - s0, 0);

    // Signed overflow
    do_op(MIN, ONES, 1'b1, 1);

    // Flush in WAIT, divider answers two cycles later
    d0 = d0_cnt; t0 = to_cnt; model_lat = 4;
    issue(1000, 10, 1'b0);
    step();
    req_valid = 1'b0;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", req_ready, 1);
    step(); step();
    check("flush_hi", hi, exp_hi);
    check("flush_lo", lo, exp_lo);
    check("flush_no_err", (d0_cnt - d0) + (to_cnt - t0), 0);

    // Divider never answers -> timeout after 64 WAIT cycles
    t0 = to_cnt; model_never = 1'b1;
    issue(5, 1, 1'b0);
    step();
    req_valid = 1'b0;
    check("to_launch", div_start, 1);
    n = 0;
    while (!err_timeout && n < 200) begin step(); n++; end
    check("timeout_cycles", n, 65);
    check("timeout_ready", req_ready, 1);
    check("timeout_hi", hi, exp_hi);
    check("timeout_lo", lo, exp_lo);
    step();
    check("timeout_pulses", to_cnt - t0, 1);
    model_never = 1'b0;

    // hilo_rd held across an operation
    hilo_rd = 1'b1; model_lat = 3;
    issue(100, 7, 1'b0);
    check("idle_rd_stall", stall, 0);
    check("idle_rd_lo", lo, exp_lo);
    step();
    req_valid = 1'b0;
    bad = 1'b0; n = 0;
    while (!req_ready && n < 100) begin
      if (!stall) bad = 1'b1;
      step();
      n++;
    end
    check("stall_busy", bad, 0);
    check("busy_cycles", n, 5);
    check("stall_idle", stall, 0);
    check("rd_lo", lo, 14);
    check("rd_hi", hi, 2);
    hilo_rd = 1'b0;

    // req_valid while busy is ignored
    d0 = d0_cnt; model_lat = 2;
    issue(50, 5, 1'b0);
    step();
    issue(9, 0, 1'b0);
    n = 0;
    while (!req_ready && n < 100) begin step(); n++; end
    req_valid = 1'b0;
    check("busy_req_lo", lo, 10);
    check("busy_req_hi", hi, 0);
    check("busy_req_no_div0", d0_cnt - d0, 0);
    step();

    // Reset mid-operation, late div_done afterwards
    model_lat = 3;
    issue(200, 3, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midrst_ready", req_ready, 1);
    step();
    rst = 1'b0;
    step(); step();
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_idle", req_ready, 1);
    check("midrst_start", div_start, 0);

    // Random operations through the scoreboard
    for (int i = 0; i < 10; i++) begin
      logic [31:0] rs, rt;
      rs = $urandom;
      rt = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) rt = 0;
      if (i == 7) rs = -rs;
      do_op(rs, rt, 1'($urandom_range(0, 1)), $urandom_range(1, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
